// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer (start, LSB-first data, optional parity, stop bits)
// paced by baud_tick, with a valid/ready word handshake on the host side.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 out_q, out_d;
    logic                 busy_q, done_q, done_d;
    logic                 last_data, last_stop, accept;

    assign last_data = cnt_q == CW'(DATA_BITS - 1);
    assign last_stop = stop_q == 1'(STOP_BITS - 1);
    assign accept    = tx_valid && state_q == IDLE;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            out_q   <= out_d;
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tx_valid ? ALIGN : IDLE;
            ALIGN:   state_d = baud_tick ? START : ALIGN;
            START:   state_d = baud_tick ? DATA : START;
            DATA:    state_d = baud_tick && last_data ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            PARITY:  state_d = baud_tick ? STOP : PARITY;
            STOP:    state_d = baud_tick && last_stop ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // The shift register always presents the next bit to send in bit 0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        par_d   = par_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (accept) begin
            shift_d = tx_data;
            par_d   = (^tx_data) ^ 1'(PARITY_ODD);
        end
        if (baud_tick) begin
            case (state_q)
                ALIGN: out_d = 1'b0;
                START: begin
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                end
                DATA: begin
                    out_d   = last_data ? (PARITY_EN != 0 ? par_q : 1'b1) : shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = last_data ? cnt_q : cnt_q + CW'(1);
                end
                PARITY: out_d = 1'b1;
                STOP: begin
                    out_d  = 1'b1;
                    stop_d = last_stop ? 1'b0 : stop_q + 1'b1;
                    done_d = last_stop;
                end
                default: ;
            endcase
        end
    end

    assign tx_ready = state_q == IDLE;
    assign tx_out   = out_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of uart_tx_ctrl across four parameter sets
// (default, odd parity, no parity, two stop bits) sharing one clock and baud tick.
module tb_uart_tx_ctrl;
    logic            sys_clk = 1'b0;
    logic            rst = 1'b1;
    logic            baud_tick = 1'b0;
    logic [3:0]      valid = 4'b0001;
    logic [3:0][7:0] data = '0;
    logic [3:0]      ready, out, busy, done;
    int              n_run = 0;
    int              n_fail = 0;
    int              w;

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        repeat (15) @(negedge sys_clk);
        baud_tick = 1'b1;
        @(negedge sys_clk);
        baud_tick = 1'b0;
    end

    uart_tx_ctrl u0 (.sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[0]),
        .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_ctrl #(.PARITY_ODD(1)) u1 (.sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[1]),
        .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_ctrl #(.PARITY_EN(0)) u2 (.sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[2]),
        .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_ctrl #(.STOP_BITS(2)) u3 (.sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[3]),
        .tx_valid(valid[3]), .tx_ready(ready[3]), .tx_out(out[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input string tag);
        int i = 0;
        while (!ready[k] && i < 100) begin
            @(negedge sys_clk);
            i++;
        end
        check({tag, "_ready"}, 16'(ready[k]), 16'd1);
        valid[k] = 1'b1;
        data[k]  = d;
        @(negedge sys_clk);
        valid[k] = 1'b0;
        data[k]  = ~d;
        check({tag, "_busy"}, {busy[k], ready[k]}, 16'b10);
    endtask

    // Waits for the start bit, then samples each bit mid-period; exp holds the frame in time order.
    task automatic capture(input int k, input int nb, input logic [15:0] exp, input string tag, output int wc);
        logic early = 1'b0;
        wc = 0;
        while (out[k] && wc < 40) begin
            @(negedge sys_clk);
            wc++;
        end
        repeat (8) @(negedge sys_clk);
        for (int i = 0; i < nb; i++) begin
            check($sformatf("%s_bit%0d", tag, i), 16'(out[k]), 16'(exp[i]));
            if (i < nb - 1)
                repeat (16) begin
                    @(negedge sys_clk);
                    early |= done[k];
                end
        end
        check({tag, "_no_early_done"}, 16'(early | done[k]), 16'd0);
    endtask

    task automatic fin(input int k, input string tag);
        int i = 0;
        while (!done[k] && i < 20) begin
            @(negedge sys_clk);
            i++;
        end
        check({tag, "_done"}, 16'(done[k]), 16'd1);
        @(negedge sys_clk);
        check({tag, "_after"}, {done[k], ready[k], busy[k], out[k]}, 16'b0101);
    endtask

    task automatic frame(input int k, input logic [7:0] d, input int nb, input logic [15:0] exp, input string tag);
        int wc;
        send(k, d, tag);
        capture(k, nb, exp, tag, wc);
        fin(k, tag);
    endtask

    initial begin
        logic seen;
        repeat (3) begin
            @(negedge sys_clk);
            check("rst_outs", {out[0], busy[0], done[0]}, 16'b100);
        end
        rst = 1'b0;
        valid[0] = 1'b0;
        @(negedge sys_clk);
        check("rst_ready", 16'(ready), 16'hf);
        repeat (40) @(negedge sys_clk);
        check("rst_no_frame", {busy, out}, {4'h0, 4'hf});

        frame(0, 8'hA5, 11, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), "def_a5");
        frame(1, 8'h07, 11, 16'({1'b1, 1'b0, 8'h07, 1'b0}), "odd_07");
        frame(2, 8'h07, 10, 16'({1'b1, 8'h07, 1'b0}), "nopar_07");
        frame(3, 8'h00, 12, 16'({2'b11, 1'b0, 8'h00, 1'b0}), "stop2_00");

        @(negedge sys_clk);
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        w = 0;
        while (ready[0] && w < 40) begin
            @(negedge sys_clk);
            w++;
        end
        check("b2b_acc1", 16'(ready[0]), 16'd0);
        data[0] = 8'hC3;
        capture(0, 11, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), "b2b_f1", w);
        w = 0;
        while (!done[0] && w < 40) begin
            @(negedge sys_clk);
            w++;
        end
        check("b2b_done1", 16'(done[0]), 16'd1);
        check("b2b_ready_in_done", 16'(ready[0]), 16'd1);
        @(negedge sys_clk);
        check("b2b_acc2", {busy[0], ready[0]}, 16'b10);
        valid[0] = 1'b0;
        @(negedge sys_clk);
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        @(negedge sys_clk);
        check("b2b_ignored_ready", 16'(ready[0]), 16'd0);
        valid[0] = 1'b0;
        capture(0, 11, 16'({1'b1, 1'b0, 8'hC3, 1'b0}), "b2b_f2", w);
        check("b2b_gap", 16'(w <= 17), 16'd1);
        fin(0, "b2b_f2");
        repeat (40) @(negedge sys_clk);
        check("b2b_no_third", {busy[0], out[0]}, 16'b01);

        send(0, 8'h0F, "rstmid");
        w = 0;
        while (out[0] && w < 40) begin
            @(negedge sys_clk);
            w++;
        end
        repeat (8 + 16 * 5) @(negedge sys_clk);
        check("rstmid_bit4", 16'(out[0]), 16'd0);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("rstmid_after", {out[0], ready[0], busy[0], done[0]}, 16'b1100);
        seen = 1'b0;
        repeat (200) begin
            @(negedge sys_clk);
            seen |= done[0] | busy[0] | ~out[0];
        end
        check("rstmid_quiet", 16'(seen), 16'd0);
        frame(0, 8'h55, 11, 16'({1'b1, 1'b0, 8'h55, 1'b0}), "post_55");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
